// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith, iterative MUL and optional DIV.
// Define ALU_DIV_EN to build the restoring divider; otherwise SEL=6 is illegal.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       SEL,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] HI,
    output logic             Z_flag,
    output logic             V_flag,
    output logic             DZ_flag,
    output logic             ERR,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_MUL  = 4'd5;
    localparam logic [3:0] OP_DIV  = 4'd6;
    localparam logic [3:0] OP_NOR  = 4'd7;
    localparam logic [3:0] OP_SLTU = 4'd8;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opd_q, opd_d;
    logic [WIDTH-1:0]     r_q, r_d, hi_q, hi_d;
    logic                 z_q, z_d, v_q, v_d, dz_q, dz_d, err_q, err_d;
    logic                 done_q, done_d;

    logic [WIDTH-1:0]     sum, dif, s_r, s_hi;
    logic                 s_v, s_dz, s_err;
    logic                 long_op, last;
    logic [WIDTH:0]       mul_add;
    logic [2*WIDTH-1:0]   mul_nxt, step;

    assign sum  = X + Y;
    assign dif  = X - Y;
    assign last = (cnt_q == CNT_W'(WIDTH - 1));

    // Accumulator holds {partial product, remaining multiplier bits}
    assign mul_add = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, opd_q} : '0);
    assign mul_nxt = {mul_add, acc_q[WIDTH-1:1]};

`ifdef ALU_DIV_EN
    logic               div_q, div_d;
    logic [WIDTH:0]     div_sub;
    logic [2*WIDTH-1:0] div_nxt;

    // Accumulator holds {remainder, dividend bits shifting into quotient}
    assign div_sub = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opd_q};
    assign div_nxt = div_sub[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                    : {div_sub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    assign step    = div_q ? div_nxt : mul_nxt;
    assign long_op = (SEL == OP_MUL) || ((SEL == OP_DIV) && (Y != '0));
`else
    assign step    = mul_nxt;
    assign long_op = (SEL == OP_MUL);
`endif

    always_comb begin
        s_r   = '0;
        s_hi  = '0;
        s_v   = 1'b0;
        s_dz  = 1'b0;
        s_err = 1'b0;
        case (SEL)
            OP_ADD: begin
                s_r = sum;
                s_v = (X[WIDTH-1] == Y[WIDTH-1]) && (sum[WIDTH-1] != X[WIDTH-1]);
            end
            OP_SUB: begin
                s_r = dif;
                s_v = (X[WIDTH-1] != Y[WIDTH-1]) && (dif[WIDTH-1] != X[WIDTH-1]);
            end
            OP_AND:  s_r = X & Y;
            OP_OR:   s_r = X | Y;
            OP_NOR:  s_r = ~(X | Y);
            OP_SLT:  s_r = {{(WIDTH-1){1'b0}}, $signed(X) < $signed(Y)};
            OP_SLTU: s_r = {{(WIDTH-1){1'b0}}, X < Y};
`ifdef ALU_DIV_EN
            OP_DIV: begin
                s_r  = '1;
                s_hi = X;
                s_dz = 1'b1;
            end
`endif
            default: s_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start && long_op) state_d = S_RUN;
            S_RUN:   if (last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_RUN);
    end

    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        opd_d  = opd_q;
        r_d    = r_q;
        hi_d   = hi_q;
        z_d    = z_q;
        v_d    = v_q;
        dz_d   = dz_q;
        err_d  = err_q;
        done_d = 1'b0;
`ifdef ALU_DIV_EN
        div_d  = div_q;
`endif
        if (state_q == S_IDLE && start) begin
            if (long_op) begin
                acc_d = {{WIDTH{1'b0}}, X};
                opd_d = Y;
                cnt_d = '0;
`ifdef ALU_DIV_EN
                div_d = (SEL == OP_DIV);
`endif
            end else begin
                r_d    = s_r;
                hi_d   = s_hi;
                z_d    = (s_r == '0);
                v_d    = s_v;
                dz_d   = s_dz;
                err_d  = s_err;
                done_d = 1'b1;
            end
        end else if (state_q == S_RUN) begin
            acc_d = step;
            cnt_d = cnt_q + CNT_W'(1);
            if (last) begin
                r_d    = step[WIDTH-1:0];
                hi_d   = step[2*WIDTH-1:WIDTH];
                z_d    = (step[WIDTH-1:0] == '0);
                v_d    = 1'b0;
                dz_d   = 1'b0;
                err_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            opd_q  <= '0;
            r_q    <= '0;
            hi_q   <= '0;
            z_q    <= 1'b1;
            v_q    <= 1'b0;
            dz_q   <= 1'b0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
`ifdef ALU_DIV_EN
            div_q  <= 1'b0;
`endif
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            opd_q  <= opd_d;
            r_q    <= r_d;
            hi_q   <= hi_d;
            z_q    <= z_d;
            v_q    <= v_d;
            dz_q   <= dz_d;
            err_q  <= err_d;
            done_q <= done_d;
`ifdef ALU_DIV_EN
            div_q  <= div_d;
`endif
        end
    end

    assign R       = r_q;
    assign HI      = hi_q;
    assign Z_flag  = z_q;
    assign V_flag  = v_q;
    assign DZ_flag = dz_q;
    assign ERR     = err_q;
    assign done    = done_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at WIDTH=32; DIV expectations follow ALU_DIV_EN.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  SEL = 4'd0;
    logic [31:0] X = '0;
    logic [31:0] Y = '0;
    logic [31:0] R, HI;
    logic        Z_flag, V_flag, DZ_flag, ERR, busy, done;

    int n_cmp = 0;
    int n_bad = 0;
    int lat, busy_n, seen;

    alu_mc #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .SEL(SEL),
        .X(X), .Y(Y), .R(R), .HI(HI), .Z_flag(Z_flag),
        .V_flag(V_flag), .DZ_flag(DZ_flag), .ERR(ERR),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op; poke_at>0 raises a stray start at that sample.
    task automatic run_op(input logic [3:0] sel, input logic [31:0] x,
                          input logic [31:0] y, input int poke_at,
                          output int l, output int b);
        SEL = sel; X = x; Y = y; start = 1'b1;
        tick();
        start = 1'b0;
        X = 32'hDEAD_BEEF;
        Y = 32'h1234_5678;
        l = 1;
        b = 0;
        while (!done && l < 100) begin
            if (busy) b++;
            if (l == poke_at) begin
                start = 1'b1;
                SEL = 4'd0;
            end
            tick();
            start = 1'b0;
            l++;
        end
        check("done_seen", {63'd0, done}, 64'd1);
    endtask

    initial begin
        repeat (3) tick();
        check("rst_R", {32'd0, R}, 64'd0);
        check("rst_HI", {32'd0, HI}, 64'd0);
        check("rst_flags", {58'd0, Z_flag, V_flag, DZ_flag, ERR, busy, done},
              64'b100000);
        rst_n = 1'b1;
        tick();

        run_op(4'd0, 32'h7FFF_FFFF, 32'd1, 0, lat, busy_n);
        check("add_lat", 64'(lat), 64'd1);
        check("add_R", {32'd0, R}, 64'h8000_0000);
        check("add_VZ", {62'd0, V_flag, Z_flag}, 64'b10);
        tick();
        check("hold_done", {63'd0, done}, 64'd0);
        check("hold_R", {32'd0, R}, 64'h8000_0000);

        SEL = 4'd1; X = 32'd5; Y = 32'd5; start = 1'b1;
        tick();
        check("sub_done", {63'd0, done}, 64'd1);
        check("sub_RZV", {R, 29'd0, Z_flag, V_flag, done}, {32'd0, 32'b101});
        SEL = 4'd4; X = 32'hFFFF_FFFF; Y = 32'd1;
        tick();
        check("slt_RZ", {R, 30'd0, Z_flag, done}, {32'd1, 32'b01});
        SEL = 4'd8;
        tick();
        check("sltu_RZ", {R, 30'd0, Z_flag, done}, {32'd0, 32'b11});
        SEL = 4'd7; X = 32'hF0F0_0000; Y = 32'h0000_00FF;
        tick();
        check("nor_R", {32'd0, R}, 64'h0F0F_FF00);
        SEL = 4'd2; X = 32'hFF00_FF00; Y = 32'h0FF0_0FF0;
        tick();
        check("and_R", {32'd0, R}, 64'h0F00_0F00);
        SEL = 4'd3;
        tick();
        check("or_R", {32'd0, R}, 64'hFFF0_FFF0);
        start = 1'b0;
        tick();

        run_op(4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, lat, busy_n);
        check("mul_lat", 64'(lat), 64'd33);
        check("mul_busy", 64'(busy_n), 64'd32);
        check("mul_HIR", {HI, R}, 64'hFFFF_FFFE_0000_0001);
        check("mul_busy_end", {63'd0, busy}, 64'd0);
        tick();
        check("mul_no_poke", {63'd0, done}, 64'd0);

        run_op(4'd5, 32'd12345, 32'd1000, 0, lat, busy_n);
        check("mul2_HIR", {HI, R}, 64'd12345000);

`ifdef ALU_DIV_EN
        run_op(4'd6, 32'd100, 32'd7, 0, lat, busy_n);
        check("div_lat", 64'(lat), 64'd33);
        check("div_busy", 64'(busy_n), 64'd32);
        check("div_HIR", {HI, R}, {32'd2, 32'd14});
        run_op(4'd6, 32'd9, 32'd0, 0, lat, busy_n);
        check("dz_lat", 64'(lat), 64'd1);
        check("dz_HIR", {HI, R}, {32'd9, 32'hFFFF_FFFF});
        check("dz_flags", {61'd0, DZ_flag, ERR, busy}, 64'b100);
`else
        run_op(4'd6, 32'd100, 32'd7, 0, lat, busy_n);
        check("div_off_lat", 64'(lat), 64'd1);
        check("div_off_busy", 64'(busy_n), 64'd0);
        check("div_off_HIR", {HI, R}, 64'd0);
        check("div_off_flags", {61'd0, ERR, Z_flag, busy}, 64'b110);
`endif

        run_op(4'd12, 32'd3, 32'd4, 0, lat, busy_n);
        check("ill_lat", 64'(lat), 64'd1);
        check("ill_HIR", {HI, R}, 64'd0);
        check("ill_flags", {60'd0, ERR, Z_flag, DZ_flag, V_flag}, 64'b1100);

        run_op(4'd0, 32'd40, 32'd2, 0, lat, busy_n);
        check("clr_R", {32'd0, R}, 64'd42);
        check("clr_flags", {60'd0, ERR, Z_flag, DZ_flag, V_flag}, 64'd0);

        SEL = 4'd5; X = 32'd3; Y = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        seen = 0;
        for (int i = 1; i < 10; i++) begin
            if (done) seen++;
            tick();
        end
        check("abort_busy_pre", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        tick();
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_HIR", {HI, R}, 64'd0);
        check("abort_ZD", {62'd0, Z_flag, done}, 64'b10);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (done) seen++;
            tick();
        end
        check("abort_no_done", 64'(seen), 64'd0);

        run_op(4'd0, 32'd2, 32'd3, 0, lat, busy_n);
        check("post_lat", 64'(lat), 64'd1);
        check("post_R", {32'd0, R}, 64'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
